// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between icache and dcache,
// routes accept/return tags, and prevents icache starvation.
//
// Ports:
//   clock, reset            - clock and synchronous active-high reset
//   proc2Imem_command/addr  - icache command (NONE/LOAD) and address
//   Icache_req_pending      - icache has a miss waiting for the bus
//   proc2Dmem_command/addr/data - dcache command (NONE/LOAD/STORE)
//   mem2proc_response       - memory accept tag, 0 = refused
//   mem2proc_data/tag       - returned data and its tag, tag 0 = none
//   proc2mem_command/addr/data - granted command driven to memory
//   Imem2proc_response/tag  - accept and return tags for the icache
//   Dmem2proc_response/tag  - accept and return tags for the dcache
//   mem2proc_data_bcast     - returned data, broadcast to both caches
//   Icache_hazard           - icache must not issue this cycle
//   Dcache_stall            - dcache request not granted this cycle
module mem_bus_arbiter #(
   parameter int NUM_TAGS     = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2Imem_command,
   input  logic [63:0] proc2Imem_addr,
   input  logic        Icache_req_pending,
   input  logic [1:0]  proc2Dmem_command,
   input  logic [63:0] proc2Dmem_addr,
   input  logic [63:0] proc2Dmem_data,
   input  logic [3:0]  mem2proc_response,
   input  logic [63:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag,
   output logic [1:0]  proc2mem_command,
   output logic [63:0] proc2mem_addr,
   output logic [63:0] proc2mem_data,
   output logic [3:0]  Imem2proc_response,
   output logic [3:0]  Imem2proc_tag,
   output logic [3:0]  Dmem2proc_response,
   output logic [3:0]  Dmem2proc_tag,
   output logic [63:0] mem2proc_data_bcast,
   output logic        Icache_hazard,
   output logic        Dcache_stall
);

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic                 icache_prio;
   logic [CNT_W-1:0]     starve_cnt;
   logic [NUM_TAGS:1]    tag_valid;
   logic [NUM_TAGS:1]    tag_icache;

   logic grant_i;
   logic grant_d;
   logic accepted;
   logic alloc;
   logic ret_hit;
   logic ret_icache;
   logic [CNT_W-1:0] starve_inc;

   // Hazard looks only at the dcache command and registered priority,
   // so the icache's own gated command never feeds back into it.
   assign Icache_hazard = (proc2Dmem_command != BUS_NONE) && !icache_prio;

   assign grant_i  = (proc2Imem_command != BUS_NONE);
   assign grant_d  = !grant_i && (proc2Dmem_command != BUS_NONE);
   assign accepted = (mem2proc_response != 4'd0);
   assign alloc    = accepted && (proc2mem_command == BUS_LOAD);

   assign Dcache_stall = (proc2Dmem_command != BUS_NONE) && grant_i;

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = 64'd0;
      proc2mem_data    = 64'd0;
      if (grant_i) begin
         proc2mem_command = proc2Imem_command;
         proc2mem_addr    = proc2Imem_addr;
      end else if (grant_d) begin
         proc2mem_command = proc2Dmem_command;
         proc2mem_addr    = proc2Dmem_addr;
         proc2mem_data    = proc2Dmem_data;
      end
   end

   assign Imem2proc_response = grant_i ? mem2proc_response : 4'd0;
   assign Dmem2proc_response = grant_d ? mem2proc_response : 4'd0;

   always_comb begin
      ret_hit    = 1'b0;
      ret_icache = 1'b0;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         if (mem2proc_tag == 4'(i) && tag_valid[i]) begin
            ret_hit    = 1'b1;
            ret_icache = tag_icache[i];
         end
      end
   end

   // Returns on invalid entries are spurious and go to nobody.
   assign Imem2proc_tag = (ret_hit && ret_icache)  ? mem2proc_tag : 4'd0;
   assign Dmem2proc_tag = (ret_hit && !ret_icache) ? mem2proc_tag : 4'd0;

   assign mem2proc_data_bcast = mem2proc_data;

   // Free first, allocate second: a tag recycled in the same cycle
   // ends up owned by the new requester.
   always_ff @(posedge clock) begin
      if (reset) begin
         tag_valid  <= '0;
         tag_icache <= '0;
      end else begin
         for (int i = 1; i <= NUM_TAGS; i++) begin
            if (ret_hit && mem2proc_tag == 4'(i)) begin
               tag_valid[i] <= 1'b0;
            end
            if (alloc && mem2proc_response == 4'(i)) begin
               tag_valid[i]  <= 1'b1;
               tag_icache[i] <= grant_i;
            end
         end
      end
   end

   assign starve_inc = (starve_cnt == CNT_MAX) ? CNT_MAX
                     : starve_cnt + CNT_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt  <= '0;
         icache_prio <= 1'b0;
      end else if (!Icache_req_pending) begin
         // Miss gone (served or squashed): forget the history.
         starve_cnt  <= '0;
         icache_prio <= 1'b0;
      end else if (grant_i && accepted) begin
         starve_cnt  <= '0;
         icache_prio <= 1'b0;
      end else if (Icache_hazard) begin
         starve_cnt <= starve_inc;
         if (starve_inc == CNT_MAX) begin
            icache_prio <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for mem_bus_arbiter.
// Expected outputs are queued per step and checked before the edge.
module tb_mem_bus_arbiter;

   localparam logic [1:0] NONE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;

   logic        clock;
   logic        reset;
   logic [1:0]  proc2Imem_command;
   logic [63:0] proc2Imem_addr;
   logic        Icache_req_pending;
   logic [1:0]  proc2Dmem_command;
   logic [63:0] proc2Dmem_addr;
   logic [63:0] proc2Dmem_data;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  Imem2proc_response;
   logic [3:0]  Imem2proc_tag;
   logic [3:0]  Dmem2proc_response;
   logic [3:0]  Dmem2proc_tag;
   logic [63:0] mem2proc_data_bcast;
   logic        Icache_hazard;
   logic        Dcache_stall;

   mem_bus_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(4)) dut (
      .clock(clock),
      .reset(reset),
      .proc2Imem_command(proc2Imem_command),
      .proc2Imem_addr(proc2Imem_addr),
      .Icache_req_pending(Icache_req_pending),
      .proc2Dmem_command(proc2Dmem_command),
      .proc2Dmem_addr(proc2Dmem_addr),
      .proc2Dmem_data(proc2Dmem_data),
      .mem2proc_response(mem2proc_response),
      .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag),
      .proc2mem_command(proc2mem_command),
      .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data),
      .Imem2proc_response(Imem2proc_response),
      .Imem2proc_tag(Imem2proc_tag),
      .Dmem2proc_response(Dmem2proc_response),
      .Dmem2proc_tag(Dmem2proc_tag),
      .mem2proc_data_bcast(mem2proc_data_bcast),
      .Icache_hazard(Icache_hazard),
      .Dcache_stall(Dcache_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic logic [63:0] observe(input string n);
      case (n)
         "cmd":    return {62'd0, proc2mem_command};
         "addr":   return proc2mem_addr;
         "data":   return proc2mem_data;
         "iresp":  return {60'd0, Imem2proc_response};
         "dresp":  return {60'd0, Dmem2proc_response};
         "itag":   return {60'd0, Imem2proc_tag};
         "dtag":   return {60'd0, Dmem2proc_tag};
         "bcast":  return mem2proc_data_bcast;
         "hazard": return {63'd0, Icache_hazard};
         "stall":  return {63'd0, Dcache_stall};
         default:  return 64'hx;
      endcase
   endfunction

   task automatic expect_val(input string n, input logic [63:0] v);
      exp_t e;
      e.name = n;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [1:0] ic, input logic [63:0] ia,
                        input logic ip, input logic [1:0] dc,
                        input logic [63:0] da, input logic [63:0] dd,
                        input logic [3:0] rs, input logic [3:0] rt);
      proc2Imem_command  = ic;
      proc2Imem_addr     = ia;
      Icache_req_pending = ip;
      proc2Dmem_command  = dc;
      proc2Dmem_addr     = da;
      proc2Dmem_data     = dd;
      mem2proc_response  = rs;
      mem2proc_tag       = rt;
   endtask

   task automatic check();
      exp_t        e;
      logic [63:0] obs;
      #3;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.name);
         n_assert++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %h expected %h",
                   e.name, $time, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic exp_bus(input logic [1:0] c, input logic [63:0] a,
                          input logic [63:0] d);
      expect_val("cmd", {62'd0, c});
      expect_val("addr", a);
      expect_val("data", d);
   endtask

   task automatic exp_resp(input logic [3:0] i, input logic [3:0] d);
      expect_val("iresp", {60'd0, i});
      expect_val("dresp", {60'd0, d});
   endtask

   task automatic exp_tag(input logic [3:0] i, input logic [3:0] d);
      expect_val("itag", {60'd0, i});
      expect_val("dtag", {60'd0, d});
   endtask

   task automatic exp_hs(input logic h, input logic s);
      expect_val("hazard", {63'd0, h});
      expect_val("stall", {63'd0, s});
   endtask

   initial begin
      mem2proc_data = 64'd0;
      reset = 1'b1;
      drive(NONE, 0, 0, NONE, 0, 0, 0, 0);
      tick();
      // reset state: idle bus, no hazard
      exp_bus(NONE, 0, 0);
      exp_resp(0, 0);
      exp_tag(0, 0);
      exp_hs(0, 0);
      check();
      tick();
      reset = 1'b0;

      // spurious return on an empty table
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd1);
      exp_tag(0, 0);
      check();
      tick();

      // icache only, load tag 3
      drive(LOAD, 64'h100, 1, NONE, 0, 0, 4'd3, 0);
      exp_bus(LOAD, 64'h100, 0);
      exp_resp(3, 0);
      exp_hs(0, 0);
      check();
      tick();

      // tag 3 returns to icache
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd3);
      mem2proc_data = 64'h0123_4567_89ab_cdef;
      exp_tag(3, 0);
      expect_val("bcast", 64'h0123_4567_89ab_cdef);
      check();
      tick();

      // tag 3 already freed
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd3);
      exp_tag(0, 0);
      check();
      tick();

      // dcache load while icache pending
      drive(NONE, 0, 1, LOAD, 64'h200, 0, 4'd5, 0);
      exp_bus(LOAD, 64'h200, 0);
      exp_resp(0, 5);
      exp_hs(1, 0);
      check();
      tick();

      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd5);
      exp_tag(0, 5);
      check();
      tick();

      // starvation: four blocked cycles (dcache refused, retrying)
      for (int k = 0; k < 4; k++) begin
         drive(NONE, 0, 1, LOAD, 64'h300, 0, 0, 0);
         exp_hs(1, 0);
         exp_resp(0, 0);
         check();
         tick();
      end
      drive(LOAD, 64'h400, 1, LOAD, 64'h300, 0, 4'd7, 0);
      exp_bus(LOAD, 64'h400, 0);
      exp_resp(7, 0);
      exp_hs(0, 1);
      check();
      tick();

      // priority returns to the dcache
      drive(NONE, 0, 1, LOAD, 64'h300, 0, 4'd6, 0);
      exp_bus(LOAD, 64'h300, 0);
      exp_resp(0, 6);
      exp_hs(1, 0);
      check();
      tick();

      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd7);
      exp_tag(7, 0);
      check();
      tick();
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd6);
      exp_tag(0, 6);
      check();
      tick();

      // store: data passes, no allocation
      drive(NONE, 0, 0, STORE, 64'h500, 64'hDEAD, 4'd2, 0);
      exp_bus(STORE, 64'h500, 64'hDEAD);
      exp_resp(0, 2);
      check();
      tick();
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd2);
      exp_tag(0, 0);
      check();
      tick();

      // refusal keeps the starvation count
      for (int k = 0; k < 3; k++) begin
         drive(NONE, 0, 1, LOAD, 64'h600, 0, 0, 0);
         exp_hs(1, 0);
         check();
         tick();
      end
      drive(LOAD, 64'h700, 1, NONE, 0, 0, 0, 0);
      exp_bus(LOAD, 64'h700, 0);
      exp_resp(0, 0);
      exp_hs(0, 0);
      check();
      tick();
      drive(NONE, 0, 1, LOAD, 64'h600, 0, 0, 0);
      exp_hs(1, 0);
      check();
      tick();
      // count reached the limit only if the refusal left it alone
      drive(LOAD, 64'h700, 1, LOAD, 64'h600, 0, 4'd8, 0);
      exp_bus(LOAD, 64'h700, 0);
      exp_resp(8, 0);
      exp_hs(0, 1);
      check();
      tick();
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd8);
      exp_tag(8, 0);
      check();
      tick();

      // tag 4 freed by icache and reallocated to dcache in one cycle
      drive(LOAD, 64'h800, 1, NONE, 0, 0, 4'd4, 0);
      exp_resp(4, 0);
      check();
      tick();
      drive(NONE, 0, 0, LOAD, 64'h900, 0, 4'd4, 4'd4);
      exp_tag(4, 0);
      exp_resp(0, 4);
      check();
      tick();
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd4);
      exp_tag(0, 4);
      check();
      tick();

      // reset invalidates outstanding tags
      drive(NONE, 0, 0, LOAD, 64'hA00, 0, 4'd9, 0);
      exp_resp(0, 9);
      check();
      tick();
      reset = 1'b1;
      drive(NONE, 0, 0, NONE, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      drive(NONE, 0, 0, NONE, 0, 0, 0, 4'd9);
      exp_tag(0, 0);
      check();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the icache (instruction loads) and the dcache (loads and stores).
- Selects one command per cycle and drives the memory port.
- Returns the memory's accept tag (response) only to the requester that was granted.
- Tracks outstanding load tags so each data-return tag reaches the requester that owns it.
- Generates the icache structural-hazard signal and the dcache stall, with anti-starvation for the icache.

Parameters:
- NUM_TAGS, 15, number of memory transaction tags; tag 0 means "none".
- STARVE_LIMIT, 4, consecutive blocked cycles after which the icache takes priority.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- proc2Imem_command  in  2  icache command (BUS_NONE/BUS_LOAD); already gated by Icache_hazard
- proc2Imem_addr  in  64  icache address
- Icache_req_pending  in  1  icache has a miss waiting for the bus
- proc2Dmem_command  in  2  dcache command (BUS_NONE/BUS_LOAD/BUS_STORE)
- proc2Dmem_addr  in  64  dcache address
- proc2Dmem_data  in  64  dcache store data
- mem2proc_response  in  4  memory accept tag; 0 = refused
- mem2proc_data  in  64  returned data
- mem2proc_tag  in  4  data-return tag; 0 = none
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  64  address to memory
- proc2mem_data  out  64  store data to memory
- Imem2proc_response  out  4  response to the icache
- Imem2proc_tag  out  4  return tag to the icache
- Dmem2proc_response  out  4  response to the dcache
- Dmem2proc_tag  out  4  return tag to the dcache
- mem2proc_data_bcast  out  64  mem2proc_data, passed straight through to both caches
- Icache_hazard  out  1  icache must not issue this cycle
- Dcache_stall  out  1  dcache request not granted this cycle

Behaviour:
- State registers:
  - icache_prio (1 bit)
  - starve_cnt, $clog2(STARVE_LIMIT+1) bits
  - owner table indexed 1..NUM_TAGS, each entry {valid, is_icache}
- Reset: all state is 0.
- Icache_hazard = (proc2Dmem_command != BUS_NONE) && !icache_prio.
  - Depends only on the dcache command and registered state.
  - This prevents a combinational loop through the icache command gating.
- Grant (combinational, same cycle):
  - Icache wins when proc2Imem_command != BUS_NONE. Hazard gating guarantees this happens only when the dcache is idle or icache_prio = 1.
  - Otherwise the dcache wins.
  - With no requests: proc2mem_command = BUS_NONE, addr = 0, data = 0.
- Dcache_stall = (proc2Dmem_command != BUS_NONE) && icache granted.
- Response routing:
  - Granted side receives mem2proc_response; the other side receives 0.
  - With no grant, both receive 0.
  - Response 0 means refused: the requester retries. No table update, no change to the starvation state.
- Allocation:
  - On a BUS_LOAD grant with response r != 0: table[r] <= {1, granted_is_icache} at the next edge.
  - Stores are accepted but never allocate an entry.
- Return routing:
  - If mem2proc_tag = t != 0 and table[t].valid: send t to the owning side only, the other side gets 0, and clear table[t].valid at the next edge.
  - If table[t] is invalid (spurious return): both return tags are 0 and the return is dropped.
- Same tag freed and re-allocated in one cycle: the allocation wins, and the entry holds the new owner.
- Starvation control:
  - If Icache_req_pending && Icache_hazard: starve_cnt increments, saturating at STARVE_LIMIT.
  - When starve_cnt reaches STARVE_LIMIT, icache_prio <= 1.
  - Icache grant with response != 0: starve_cnt <= 0, icache_prio <= 0.
  - Icache_req_pending falling to 0: starve_cnt <= 0, icache_prio <= 0. This covers a miss squashed by a branch.
- Reset mid-operation: all table entries are invalidated, and any later returns for those tags are dropped as spurious.
- Latency: zero cycles from command to memory, and zero cycles from tag return to the requester.

Test Plan:
- Icache only: BUS_LOAD at addr 0x100, response=3 → proc2mem_addr=0x100, Imem2proc_response=3, Dmem2proc_response=0. A later tag=3 → Imem2proc_tag=3, Dmem2proc_tag=0, and entry 3 is freed.
- Simultaneous: dcache BUS_LOAD at 0x200 with icache pending → Icache_hazard=1, the dcache is granted, response=5 routes to the dcache, and tag 5 later returns to the dcache only.
- Starvation: dcache requests every cycle with Icache_req_pending=1 → after 4 blocked cycles, Icache_hazard=0 and icache_prio=1. The icache is granted with Dcache_stall=1 and response=7. The next cycle the dcache has priority again.
- Store: dcache BUS_STORE with data 0xDEAD, response=2 → proc2mem_data=0xDEAD, no entry allocated. A stray tag=2 → both tags are 0.
- Refusal: icache granted with response=0 → Imem2proc_response=0, no allocation, starve_cnt unchanged, and the retry next cycle succeeds.
- Tag reuse plus reset: tag 4 returns to the icache while response=4 is granted to the dcache in the same cycle → the entry now belongs to the dcache. Then assert reset and return tag 4 → both return tags are 0.
